iir_tap_sequencer: RTL
======================

// Module: iir_tap_sequencer
// PURPOSE
//  Sequences a shared stereo IIR tap chain for one audio sample pair. Accepts L/R samples via
//  valid/ready, drives tap_ce/tap_ch and the scaled tap_x for each channel, and waits for the
//  chain to settle. Captures and saturates the chain output. Owns double-buffered coefficients,
//  committed only between samples. Sits between the audio mixer and the tap chain.
// PARAMETERS
//  STAGES  3   number of taps in the chain (coefficient sets)
//  SETTLE  2   cycles waited after tap_ce before capturing tap_y (>=1)
//  SHIFT   20  fixed-point position of 16-bit samples inside 40-bit tap words
// PORTS
//  clk         in   1            system clock
//  reset_n     in   1            async active-low reset
//  in_valid    in   1            sample pair valid
//  in_ready    out  1            sequencer can accept a pair
//  in_l/in_r   in   16           signed input samples
//  bypass      in   1            sampled at accept; pass-through, taps untouched
//  flush       in   1            request clear of tap state
//  out_valid   out  1            output pair valid
//  out_ready   in   1            consumer accepts output
//  out_l/out_r out  16           signed filtered/saturated samples
//  tap_ce      out  1            tap update strobe
//  tap_ch      out  1            channel select (0=L, 1=R)
//  tap_clr     out  1            one-cycle tap state clear
//  tap_x       out  40           chain input word
//  tap_y       in   40           chain output word (combinational from tap state)
//  cfg_we      in   1            write shadow set cfg_stage
//  cfg_stage   in   $clog2(STAGES)  shadow index (>=STAGES ignored)
//  cfg_cx      in   8            shadow cx
//  cfg_cy      in   24           shadow cy
//  cfg_commit  in   1            request shadow->active copy
//  cfg_pending out  1            commit requested, not yet applied
//  coef_cx     out  8*STAGES     active cx, stage k at [8k+:8]
//  coef_cy     out  24*STAGES    active cy, stage k at [24k+:24]
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE.
//   - All outputs 0; active and shadow coefficients 0; cfg_pending 0.
//   - Mid-sample reset abandons the sample with no output.
//  States: IDLE, RUN(ch), WAIT(ch), CAP(ch), DONE, CLR.
//  IDLE:
//   - in_ready = 1 iff out_valid=0 and flush=0.
//   - Accept on in_valid&in_ready: latch in_l/in_r and bypass.
//   - bypass=1: load out_l/out_r = inputs and set out_valid next edge; latency 1; no tap_ce.
//   - bypass=0: go to RUN(0).
//   - If cfg_pending, active<=shadow and cfg_pending<=0 in every IDLE cycle.
//     A commit pending at accept applies to that sample.
//  flush in IDLE (has priority over accept): go CLR.
//   - CLR: tap_clr=1 for exactly one cycle, then IDLE.
//  RUN(ch): tap_ce=1 one cycle; tap_ch=ch.
//   - tap_x = sext40(sample[ch]) <<< SHIFT.
//   - tap_ch and tap_x are held constant through WAIT and CAP.
//  WAIT(ch): SETTLE cycles, tap_ce=0.
//  CAP(ch): out_{ch} <= sat16(tap_y >>> SHIFT), clamped to [-32768, 32767].
//   - ch=0 -> RUN(1); ch=1 -> DONE with out_valid=1.
//  Latency: out_valid rises 4+2*SETTLE edges after the accept edge (8 at default).
//  DONE: out_valid, out_l and out_r are held until out_ready=1, then cleared.
//   - Next accept is possible the cycle after.
//  tap_ce is never asserted outside RUN; exactly 2 pulses per non-bypass sample.
//  Config:
//   - cfg_we writes shadow in any state.
//   - cfg_commit sets cfg_pending. Active coefficients never change outside IDLE.
//   - cfg_we and cfg_commit in the same cycle: the write is included in the commit.
//   - Commit during a sample is deferred to the next IDLE cycle.
// TESTING
//  1. SETTLE=2; in_l=0x1000, in_r=-0x1000, tap_y model = tap_x:
//     - out_valid 8 edges after accept; out_l=0x1000, out_r=0xF000.
//     - tap_ce exactly 2 pulses; tap_ch 0 then 1.
//  2. tap_y = 40'h7F_FFFF_FFFF -> out=0x7FFF;
//     tap_y = 40'h80_0000_0000 -> out=0x8000 (saturation both rails).
//  3. bypass=1, in_l=0x1234 -> out_l=0x1234 after 1 edge; tap_ce stays 0.
//  4. cfg_commit mid-sample:
//     - coef_cx/coef_cy unchanged until DONE->IDLE; then equal shadow; cfg_pending drops.
//  5. Backpressure: out_ready=0 for 10 cycles -> outputs stable, in_ready=0; release -> one transfer.
//  6. flush and in_valid together in IDLE -> tap_clr one cycle, sample accepted after CLR;
//     reset_n low during WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/iir_tap_sequencer.sv
// iir_tap_sequencer: steps one L/R sample pair through a shared IIR tap chain,
// saturates the chain output and owns double-buffered coefficients.
module iir_tap_sequencer #(
  parameter int STAGES = 3,
  parameter int SETTLE = 2,
  parameter int SHIFT  = 20,
  localparam int SW = STAGES > 1 ? $clog2(STAGES) : 1,
  localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0]          in_l,
  input  logic [15:0]          in_r,
  input  logic                 bypass,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          out_l,
  output logic [15:0]          out_r,
  output logic                 tap_ce,
  output logic                 tap_ch,
  output logic                 tap_clr,
  output logic [39:0]          tap_x,
  input  logic [39:0]          tap_y,
  input  logic                 cfg_we,
  input  logic [SW-1:0]        cfg_stage,
  input  logic [7:0]           cfg_cx,
  input  logic [23:0]          cfg_cy,
  input  logic                 cfg_commit,
  output logic                 cfg_pending,
  output logic [8*STAGES-1:0]  coef_cx,
  output logic [24*STAGES-1:0] coef_cy
);
  typedef enum logic [2:0] {IDLE, RUN, WAIT, CAP, DONE, CLR} state_t;
  state_t                r_state;
  logic                  r_ch;
  logic [CW-1:0]         r_cnt;
  logic [15:0]           r_smp_r;
  logic [8*STAGES-1:0]   r_sh_cx;
  logic [24*STAGES-1:0]  r_sh_cy;
  logic [39:0]           w_x_l;
  logic [39:0]           w_x_r;
  logic signed [39:0]    w_shr;
  logic [15:0]           w_sat;
  assign in_ready = reset_n && r_state == IDLE && !out_valid && !flush;
  assign w_x_l = {{24{in_l[15]}}, in_l} << SHIFT;
  assign w_x_r = {{24{r_smp_r[15]}}, r_smp_r} << SHIFT;
  assign w_shr = $signed(tap_y) >>> SHIFT;
  // the shifted word fits in 16 bits only when bits 39..15 are all sign copies
  assign w_sat = (&w_shr[39:15] || ~|w_shr[39:15]) ? w_shr[15:0] : (w_shr[39] ? 16'h8000 : 16'h7FFF);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_ch        <= 1'b0;
      r_cnt       <= '0;
      r_smp_r     <= '0;
      r_sh_cx     <= '0;
      r_sh_cy     <= '0;
      out_valid   <= 1'b0;
      out_l       <= '0;
      out_r       <= '0;
      tap_ce      <= 1'b0;
      tap_ch      <= 1'b0;
      tap_clr     <= 1'b0;
      tap_x       <= '0;
      cfg_pending <= 1'b0;
      coef_cx     <= '0;
      coef_cy     <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++)
        if (cfg_we && cfg_stage == SW'(k)) begin
          r_sh_cx[8*k +: 8]   <= cfg_cx;
          r_sh_cy[24*k +: 24] <= cfg_cy;
        end
      // a commit arriving with a write copies on a later edge, so it sees that write
      if (cfg_commit) cfg_pending <= 1'b1;
      else if (r_state == IDLE) cfg_pending <= 1'b0;
      if (r_state == IDLE && cfg_pending) begin
        coef_cx <= r_sh_cx;
        coef_cy <= r_sh_cy;
      end
      tap_ce  <= 1'b0;
      tap_clr <= 1'b0;
      case (r_state)
        IDLE:
          if (flush) begin
            tap_clr <= 1'b1;
            r_state <= CLR;
          end else if (in_valid) begin
            r_smp_r <= in_r;
            if (bypass) begin
              out_l     <= in_l;
              out_r     <= in_r;
              out_valid <= 1'b1;
              r_state   <= DONE;
            end else begin
              r_ch    <= 1'b0;
              tap_ch  <= 1'b0;
              tap_x   <= w_x_l;
              tap_ce  <= 1'b1;
              r_state <= RUN;
            end
          end
        RUN: begin
          r_cnt   <= CW'(SETTLE - 1);
          r_state <= WAIT;
        end
        WAIT:
          if (r_cnt == '0) r_state <= CAP;
          else r_cnt <= r_cnt - 1'b1;
        CAP:
          if (!r_ch) begin
            out_l   <= w_sat;
            r_ch    <= 1'b1;
            tap_ch  <= 1'b1;
            tap_x   <= w_x_r;
            tap_ce  <= 1'b1;
            r_state <= RUN;
          end else begin
            out_r     <= w_sat;
            out_valid <= 1'b1;
            r_state   <= DONE;
          end
        DONE:
          if (out_ready) begin
            out_valid <= 1'b0;
            out_l     <= '0;
            out_r     <= '0;
            r_state   <= IDLE;
          end
        CLR: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
